// File: rtl/gp_register.sv
// General-purpose datapath register: synchronous active-high reset,
// loads d on a rising edge when wr_ctrl is set, otherwise holds.
module gp_register #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_ctrl,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Ternary rather than if/else on wr_ctrl so an unknown enable propagates
  // into q in four-state simulation instead of being silently treated as 0.
  always_ff @(posedge clk) begin
    if (rst) q <= RESET_VALUE;
    else     q <= wr_ctrl ? d : q;
  end

endmodule

// File: tb/tb_gp_register.sv
// Bench for gp_register: directed cases plus random traffic against a
// reference model, and a 16-bit instance with a non-zero reset value.
module tb_gp_register;

  logic        clk = 1'b0;
  logic        rst, wr_ctrl;
  logic [7:0]  d, q;
  logic        rst16, wr16;
  logic [15:0] d16, q16;

  logic [7:0]  model;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  gp_register dut (
    .clk(clk), .rst(rst), .wr_ctrl(wr_ctrl), .d(d), .q(q)
  );

  gp_register #(.WIDTH(16), .RESET_VALUE(16'h0080)) dut16 (
    .clk(clk), .rst(rst16), .wr_ctrl(wr16), .d(d16), .q(q16)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, take the edge, update the model, check mid-cycle.
  task automatic cyc(input string tag, input logic r, input logic w, input logic [7:0] dv);
    rst = r; wr_ctrl = w; d = dv;
    @(posedge clk);
    if (r)      model = 8'h00;
    else if (w) model = dv;
    @(negedge clk);
    chk(tag, {8'h00, q}, {8'h00, model});
  endtask

  logic [7:0] gv_d   [6] = '{8'h55, 8'hAA, 8'hAA, 8'h0F, 8'hF0, 8'h00};
  logic       gv_w   [6] = '{1'b1,  1'b0,  1'b1,  1'b0,  1'b1,  1'b1};
  logic [7:0] gv_exp [6] = '{8'h55, 8'h55, 8'hAA, 8'hAA, 8'hF0, 8'h00};

  initial begin
    rst16 = 1'b1; wr16 = 1'b0; d16 = 16'h0000;
    model = 8'h00;

    // Reset state, then preload A5 and reset it away.
    cyc("reset_initial", 1'b1, 1'b0, 8'h00);
    cyc("load_a5", 1'b0, 1'b1, 8'hA5);
    #2 rst = 1'b1; wr_ctrl = 1'b0;
    #1 chk("rst_mid_period_no_effect", {8'h00, q}, 16'h00A5);
    cyc("reset_from_a5", 1'b1, 1'b0, 8'h00);
    chk("reset_value_const", {8'h00, q}, 16'h0000);

    // Back-to-back loads.
    cyc("load_1010_1010", 1'b0, 1'b1, 8'b1010_1010);
    chk("load_aa_const", {8'h00, q}, 16'h00AA);
    cyc("back_to_back_ff", 1'b0, 1'b1, 8'hFF);
    chk("load_ff_const", {8'h00, q}, 16'h00FF);

    // Hold while d toggles.
    cyc("load_3c", 1'b0, 1'b1, 8'h3C);
    for (int i = 0; i < 3; i++) begin
      cyc("hold_toggle", 1'b0, 1'b0, (i % 2 == 0) ? 8'h00 : 8'hFF);
      chk("hold_3c_const", {8'h00, q}, 16'h003C);
    end

    // Reset wins over a simultaneous write; write lands on the next edge.
    cyc("rst_beats_write", 1'b1, 1'b1, 8'h77);
    chk("rst_beats_write_const", {8'h00, q}, 16'h0000);
    cyc("write_after_rst", 1'b0, 1'b1, 8'h77);
    chk("write_after_rst_const", {8'h00, q}, 16'h0077);

    // Multi-cycle reset.
    for (int i = 0; i < 3; i++) begin
      cyc("rst_held", 1'b1, 1'b1, 8'hC3);
      chk("rst_held_const", {8'h00, q}, 16'h0000);
    end

    // Golden vector sequence.
    for (int i = 0; i < 6; i++) begin
      cyc("golden_seq", 1'b0, gv_w[i], gv_d[i]);
      chk("golden_const", {8'h00, q}, {8'h00, gv_exp[i]});
    end

    // Random traffic against the model.
    for (int i = 0; i < 300; i++) begin
      cyc("random", ($urandom_range(0, 15) == 0), $urandom_range(0, 1) == 1,
          8'($urandom));
    end

    // 16-bit instance with non-zero reset value (held in reset so far).
    @(negedge clk);
    chk("w16_reset_value", q16, 16'h0080);
    rst16 = 1'b0; wr16 = 1'b1; d16 = 16'hBEEF;
    @(posedge clk);
    @(negedge clk);
    chk("w16_write_beef", q16, 16'hBEEF);
    wr16 = 1'b0; d16 = 16'h1234;
    @(posedge clk);
    @(negedge clk);
    chk("w16_hold", q16, 16'hBEEF);
    rst16 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("w16_reset_again", q16, 16'h0080);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
